// File: rtl/tetris_pkg.sv
// Shared types, playfield size and spawn shape table for the falling-piece logic.
package tetris_pkg;
  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int CELLS = COLS * ROWS;
  localparam int IDX_W = $clog2(CELLS);

  typedef logic [4:0]        coord_t;
  typedef logic signed [5:0] cand_t;
  typedef logic [IDX_W-1:0]  cell_idx_t;

  typedef enum logic [2:0] {P_I, P_O, P_T, P_S, P_Z, P_J, P_L, P_X} piece_t;
  typedef enum logic [2:0] {ST_SPAWN, ST_FALL, ST_CHECK, ST_LOCK, ST_OVER} ctrl_state_t;
  typedef enum logic [2:0] {OP_SPAWN, OP_LEFT, OP_RIGHT, OP_ROT, OP_DOWN} op_t;

  // Element [3] is block 3; block 1 is always the rotation pivot.
  typedef struct packed {
    logic [3:0][1:0] sx;
    logic [3:0][1:0] sy;
  } shape_t;

  function automatic shape_t spawn_shape(piece_t p);
    shape_t s;
    case (p)
      P_O:     begin s.sx = {2'd2, 2'd1, 2'd2, 2'd1}; s.sy = {2'd1, 2'd1, 2'd0, 2'd0}; end
      P_T:     begin s.sx = {2'd1, 2'd2, 2'd1, 2'd0}; s.sy = {2'd1, 2'd0, 2'd0, 2'd0}; end
      P_S:     begin s.sx = {2'd1, 2'd0, 2'd2, 2'd1}; s.sy = {2'd1, 2'd1, 2'd0, 2'd0}; end
      P_Z:     begin s.sx = {2'd2, 2'd1, 2'd1, 2'd0}; s.sy = {2'd1, 2'd1, 2'd0, 2'd0}; end
      P_J:     begin s.sx = {2'd2, 2'd2, 2'd1, 2'd0}; s.sy = {2'd1, 2'd0, 2'd0, 2'd0}; end
      P_L:     begin s.sx = {2'd0, 2'd2, 2'd1, 2'd0}; s.sy = {2'd1, 2'd0, 2'd0, 2'd0}; end
      default: begin s.sx = {2'd3, 2'd2, 2'd1, 2'd0}; s.sy = {2'd0, 2'd0, 2'd0, 2'd0}; end
    endcase
    return s;
  endfunction

  function automatic cell_idx_t cell_index(coord_t cx, coord_t cy);
    return cell_idx_t'(cy) * cell_idx_t'(COLS) + cell_idx_t'(cx);
  endfunction
endpackage

// File: rtl/piece_controller_if.sv
// Signals between the piece controller and its neighbours (keys, generator, board store, renderer).
interface piece_controller_if;
  import tetris_pkg::*;

  logic             frame_tick;
  logic             cmd_left;
  logic             cmd_right;
  logic             cmd_rot;
  logic             cmd_down;
  logic [2:0]       piece_type;
  logic             next_req;
  logic [CELLS-1:0] board_occ;
  coord_t           x [4];
  coord_t           y [4];
  logic             piece_active;
  logic             lock_valid;
  logic             lock_ready;
  logic             game_over;

  modport master (
    input  frame_tick, cmd_left, cmd_right, cmd_rot, cmd_down, piece_type, board_occ, lock_ready,
    output next_req, x, y, piece_active, lock_valid, game_over
  );

  modport slave (
    output frame_tick, cmd_left, cmd_right, cmd_rot, cmd_down, piece_type, board_occ, lock_ready,
    input  next_req, x, y, piece_active, lock_valid, game_over
  );
endinterface

// File: rtl/piece_collide.sv
// Combinational wall/board overlap test for a four-block candidate position.
module piece_collide
  import tetris_pkg::*;
(
  input  cand_t            cand_x [4],
  input  cand_t            cand_y [4],
  input  logic [CELLS-1:0] board_occ,
  output logic             collide
);

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cand_x[i][5] || cand_y[i][5] || cand_x[i] >= cand_t'(COLS) || cand_y[i] >= cand_t'(ROWS))
        collide = 1'b1;
      else if (board_occ[cell_index(cand_x[i][4:0], cand_y[i][4:0])])
        collide = 1'b1;
    end
  end

endmodule

// File: rtl/piece_controller.sv
// Falling tetromino sequencer: spawn, gravity, moves/rotation, landing and lock handoff.
//   state    | meaning
//   SPAWN    | load next shape as candidate, pulse next_req
//   FALL     | accept one op (gravity > down > rot > left > right)
//   CHECK    | test candidate against walls/board, commit or reject
//   LOCK     | landed, hold lock_valid until board store takes it
//   OVER     | spawn collided, frozen until reset
module piece_controller
  import tetris_pkg::*;
#(
  parameter int DROP_FRAMES = 30,
  parameter int SPAWN_COL   = 3
) (
  input logic                Clk,
  input logic                Reset,
  piece_controller_if.master bus
);

  localparam int CNT_W = (DROP_FRAMES > 1) ? $clog2(DROP_FRAMES) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(DROP_FRAMES - 1);

  ctrl_state_t state, state_nxt;
  op_t         op, op_nxt;
  coord_t      x_q [4], x_nxt [4], y_q [4], y_nxt [4];
  cand_t       cx_q [4], cx_nxt [4], cy_q [4], cy_nxt [4];
  cand_t       rot_x [4], rot_y [4];
  logic        active, active_nxt, over, over_nxt, is_o, is_o_nxt;
  logic        grav, grav_nxt, grav_fire;
  cnt_t        drop_cnt, drop_nxt;
  logic        collide;
  shape_t      shape;

  assign shape = spawn_shape(piece_t'(bus.piece_type));

  piece_collide u_collide (
    .cand_x    (cx_q),
    .cand_y    (cy_q),
    .board_occ (bus.board_occ),
    .collide   (collide)
  );

  // Clockwise turn about block 1: (px-(y-py), py+(x-px)).
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rot_x[i] = cand_t'(x_q[1]) - (cand_t'(y_q[i]) - cand_t'(y_q[1]));
      rot_y[i] = cand_t'(y_q[1]) + (cand_t'(x_q[i]) - cand_t'(x_q[1]));
    end
  end

  always_comb begin
    state_nxt  = state;
    op_nxt     = op;
    x_nxt      = x_q;
    y_nxt      = y_q;
    cx_nxt     = cx_q;
    cy_nxt     = cy_q;
    active_nxt = active;
    over_nxt   = over;
    is_o_nxt   = is_o;
    grav_nxt   = grav;
    drop_nxt   = drop_cnt;
    grav_fire  = 1'b0;

    if (bus.frame_tick && (state == ST_FALL || state == ST_CHECK)) begin
      if (drop_cnt == CNT_LAST) begin
        drop_nxt  = '0;
        grav_fire = 1'b1;
        grav_nxt  = 1'b1;
      end else begin
        drop_nxt = drop_cnt + cnt_t'(1);
      end
    end

    unique case (state)
      ST_SPAWN: begin
        for (int i = 0; i < 4; i++) begin
          cx_nxt[i] = cand_t'(SPAWN_COL) + cand_t'(shape.sx[i]);
          cy_nxt[i] = cand_t'(shape.sy[i]);
        end
        is_o_nxt  = (piece_t'(bus.piece_type) == P_O);
        drop_nxt  = '0;
        op_nxt    = OP_SPAWN;
        state_nxt = ST_CHECK;
      end
      ST_FALL: begin
        if (grav || bus.cmd_down) begin
          for (int i = 0; i < 4; i++) begin
            cx_nxt[i] = cand_t'(x_q[i]);
            cy_nxt[i] = cand_t'(y_q[i]) + cand_t'(1);
          end
          op_nxt    = OP_DOWN;
          state_nxt = ST_CHECK;
          // A tick landing in the same cycle starts the next gravity step.
          if (grav) grav_nxt = grav_fire;
          else      drop_nxt = '0;
        end else if (bus.cmd_rot) begin
          for (int i = 0; i < 4; i++) begin
            cx_nxt[i] = is_o ? cand_t'(x_q[i]) : rot_x[i];
            cy_nxt[i] = is_o ? cand_t'(y_q[i]) : rot_y[i];
          end
          op_nxt    = OP_ROT;
          state_nxt = ST_CHECK;
        end else if (bus.cmd_left || bus.cmd_right) begin
          for (int i = 0; i < 4; i++) begin
            cx_nxt[i] = bus.cmd_left ? cand_t'(x_q[i]) - cand_t'(1) : cand_t'(x_q[i]) + cand_t'(1);
            cy_nxt[i] = cand_t'(y_q[i]);
          end
          op_nxt    = bus.cmd_left ? OP_LEFT : OP_RIGHT;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!collide || op == OP_SPAWN) begin
          for (int i = 0; i < 4; i++) begin
            x_nxt[i] = cx_q[i][4:0];
            y_nxt[i] = cy_q[i][4:0];
          end
        end
        if (!collide) begin
          state_nxt = ST_FALL;
          if (op == OP_SPAWN) active_nxt = 1'b1;
        end else begin
          unique case (op)
            OP_DOWN:  state_nxt = ST_LOCK;
            OP_SPAWN: begin
              active_nxt = 1'b1;
              over_nxt   = 1'b1;
              state_nxt  = ST_OVER;
            end
            default:  state_nxt = ST_FALL;
          endcase
        end
      end
      ST_LOCK: begin
        if (bus.lock_ready) begin
          state_nxt  = ST_SPAWN;
          active_nxt = 1'b0;
        end
      end
      ST_OVER: state_nxt = ST_OVER;
      default: state_nxt = ST_SPAWN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_SPAWN;
      op       <= OP_SPAWN;
      x_q      <= '{default: '0};
      y_q      <= '{default: '0};
      cx_q     <= '{default: '0};
      cy_q     <= '{default: '0};
      active   <= 1'b0;
      over     <= 1'b0;
      is_o     <= 1'b0;
      grav     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      op       <= op_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      cx_q     <= cx_nxt;
      cy_q     <= cy_nxt;
      active   <= active_nxt;
      over     <= over_nxt;
      is_o     <= is_o_nxt;
      grav     <= grav_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.piece_active = active;
  assign bus.game_over    = over;
  assign bus.lock_valid   = (state == ST_LOCK);
  assign bus.next_req     = (state == ST_SPAWN) && !Reset;

endmodule

// File: tb/tb_piece_controller.sv
// Self-checking bench: directed scenarios plus random commands against a cell-level reference model.
module tb_piece_controller;
  import tetris_pkg::*;

  localparam int DF = 2;
  localparam int SC = 3;
  localparam int M_SPAWN = 0, M_FALL = 1, M_CHECK = 2, M_LOCK = 3, M_OVER = 4;
  localparam int K_SPAWN = 0, K_MOVE = 1, K_DOWN = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  piece_controller_if bus ();

  piece_controller #(.DROP_FRAMES(DF), .SPAWN_COL(SC)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: piece cells as plain integers.
  int sh_x [8][4] = '{'{0,1,2,3}, '{1,2,1,2}, '{0,1,2,1}, '{1,2,0,1},
                      '{0,1,1,2}, '{0,1,2,2}, '{0,1,2,0}, '{0,1,2,3}};
  int sh_y [8][4] = '{'{0,0,0,0}, '{0,0,1,1}, '{0,0,0,1}, '{0,0,1,1},
                      '{0,0,1,1}, '{0,0,0,1}, '{0,0,0,1}, '{0,0,0,0}};
  int m_ph, m_kind, m_cnt;
  int m_x [4], m_y [4], m_cx [4], m_cy [4];
  bit m_act, m_over, m_grav, m_is_o, m_lock_hs;

  function automatic logic [19:0] pk4(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [19:0] pack_c(input coord_t c [4]);
    return {c[3], c[2], c[1], c[0]};
  endfunction

  function automatic bit m_collides();
    for (int i = 0; i < 4; i++) begin
      if (m_cx[i] < 0 || m_cx[i] >= COLS || m_cy[i] < 0 || m_cy[i] >= ROWS) return 1'b1;
      if (bus.board_occ[8'(m_cy[i] * COLS + m_cx[i])]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic m_reset();
    m_ph = M_SPAWN; m_kind = K_SPAWN; m_cnt = 0;
    m_act = 0; m_over = 0; m_grav = 0; m_is_o = 0;
    for (int i = 0; i < 4; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_cx[i] = 0; m_cy[i] = 0;
    end
  endtask

  task automatic m_commit();
    for (int i = 0; i < 4; i++) begin
      m_x[i] = m_cx[i]; m_y[i] = m_cy[i];
    end
  endtask

  task automatic model_step();
    bit was_pending, fired;
    int t;
    m_lock_hs = 0;
    if (reset) begin
      m_reset();
      return;
    end
    was_pending = m_grav;
    fired = 0;
    if (bus.frame_tick && (m_ph == M_FALL || m_ph == M_CHECK)) begin
      if (m_cnt == DF - 1) begin m_cnt = 0; m_grav = 1; fired = 1; end
      else m_cnt++;
    end
    case (m_ph)
      M_SPAWN: begin
        t = int'(bus.piece_type);
        for (int i = 0; i < 4; i++) begin
          m_cx[i] = sh_x[t][i] + SC; m_cy[i] = sh_y[t][i];
        end
        m_is_o = (t == 1); m_cnt = 0; m_kind = K_SPAWN; m_ph = M_CHECK;
      end
      M_FALL: begin
        if (was_pending || bus.cmd_down) begin
          for (int i = 0; i < 4; i++) begin m_cx[i] = m_x[i]; m_cy[i] = m_y[i] + 1; end
          m_kind = K_DOWN; m_ph = M_CHECK;
          if (was_pending) m_grav = fired; else m_cnt = 0;
        end else if (bus.cmd_rot) begin
          for (int i = 0; i < 4; i++) begin
            m_cx[i] = m_is_o ? m_x[i] : m_x[1] - (m_y[i] - m_y[1]);
            m_cy[i] = m_is_o ? m_y[i] : m_y[1] + (m_x[i] - m_x[1]);
          end
          m_kind = K_MOVE; m_ph = M_CHECK;
        end else if (bus.cmd_left || bus.cmd_right) begin
          for (int i = 0; i < 4; i++) begin
            m_cx[i] = bus.cmd_left ? m_x[i] - 1 : m_x[i] + 1; m_cy[i] = m_y[i];
          end
          m_kind = K_MOVE; m_ph = M_CHECK;
        end
      end
      M_CHECK: begin
        if (!m_collides()) begin
          m_commit();
          if (m_kind == K_SPAWN) m_act = 1;
          m_ph = M_FALL;
        end else if (m_kind == K_DOWN) m_ph = M_LOCK;
        else if (m_kind == K_SPAWN) begin
          m_commit(); m_act = 1; m_over = 1; m_ph = M_OVER;
        end else m_ph = M_FALL;
      end
      M_LOCK: if (bus.lock_ready) begin m_lock_hs = 1; m_act = 0; m_ph = M_SPAWN; end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_val("x", 32'(pack_c(bus.x)), 32'(pk4(m_x[0], m_x[1], m_x[2], m_x[3])));
    check_val("y", 32'(pack_c(bus.y)), 32'(pk4(m_y[0], m_y[1], m_y[2], m_y[3])));
    check_val("piece_active", 32'(bus.piece_active), 32'(m_act));
    check_val("game_over", 32'(bus.game_over), 32'(m_over));
    check_val("lock_valid", 32'(bus.lock_valid), 32'(m_ph == M_LOCK));
    check_val("next_req", 32'(bus.next_req), 32'(m_ph == M_SPAWN && !reset));
  endtask

  // One clock: check current outputs, advance model, clock DUT, act as board store, clear pulses.
  task automatic step();
    #1;
    compare_all();
    model_step();
    @(posedge clk);
    #1;
    if (m_lock_hs)
      for (int i = 0; i < 4; i++) bus.board_occ[8'(m_y[i] * COLS + m_x[i])] = 1'b1;
    bus.frame_tick = 0; bus.cmd_left = 0; bus.cmd_right = 0; bus.cmd_rot = 0; bus.cmd_down = 0;
  endtask

  task automatic do_reset();
    reset = 1; step(); step(); reset = 0;
  endtask

  task automatic cmd(input int which);
    case (which)
      0: bus.cmd_left = 1;
      1: bus.cmd_right = 1;
      2: bus.cmd_rot = 1;
      default: bus.cmd_down = 1;
    endcase
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.frame_tick = 0; bus.cmd_left = 0; bus.cmd_right = 0; bus.cmd_rot = 0; bus.cmd_down = 0;
    bus.piece_type = 3'd2; bus.board_occ = '0; bus.lock_ready = 0;
    m_reset();
    @(posedge clk); #1;
    do_reset();
    check_val("rst_x", 32'(pack_c(bus.x)), 32'd0);
    check_val("rst_active", 32'(bus.piece_active), 32'd0);
    check_val("rst_lock_valid", 32'(bus.lock_valid), 32'd0);

    // T spawn, rejected rotation, then rotation one row lower
    step();
    check_val("t_nreq_once", 32'(bus.next_req), 32'd0);
    step();
    check_val("t_spawn_x", 32'(pack_c(bus.x)), 32'(pk4(3, 4, 5, 4)));
    check_val("t_spawn_y", 32'(pack_c(bus.y)), 32'(pk4(0, 0, 0, 1)));
    check_val("t_spawn_active", 32'(bus.piece_active), 32'd1);
    cmd(2);
    check_val("t_rot_reject_x", 32'(pack_c(bus.x)), 32'(pk4(3, 4, 5, 4)));
    cmd(3); cmd(2);
    check_val("t_rot_x", 32'(pack_c(bus.x)), 32'(pk4(4, 4, 4, 3)));
    check_val("t_rot_y", 32'(pack_c(bus.y)), 32'(pk4(0, 1, 2, 1)));

    // I piece against the left wall, then gravity beats a same-cycle left
    do_reset();
    bus.piece_type = 3'd0;
    step(); step();
    cmd(0); cmd(0); cmd(0);
    check_val("i_left3_x", 32'(pack_c(bus.x)), 32'(pk4(0, 1, 2, 3)));
    cmd(0);
    check_val("i_left_wall_x", 32'(pack_c(bus.x)), 32'(pk4(0, 1, 2, 3)));
    bus.frame_tick = 1; step();
    bus.frame_tick = 1; step();
    bus.frame_tick = 1; bus.cmd_left = 1; step();
    step();
    check_val("grav_prio_x", 32'(pack_c(bus.x)), 32'(pk4(0, 1, 2, 3)));
    check_val("grav_prio_y", 32'(pack_c(bus.y)), 32'(pk4(1, 1, 1, 1)));

    // Fall to the floor, hold the lock, then release it
    for (int k = 0; k < 200 && !bus.lock_valid; k++) begin
      bus.frame_tick = 1; step();
    end
    check_val("lock_reached", 32'(bus.lock_valid), 32'd1);
    check_val("lock_y", 32'(pack_c(bus.y)), 32'(pk4(19, 19, 19, 19)));
    bus.lock_ready = 0;
    repeat (5) step();
    check_val("lock_hold_x", 32'(pack_c(bus.x)), 32'(pk4(0, 1, 2, 3)));
    check_val("lock_hold_valid", 32'(bus.lock_valid), 32'd1);
    bus.lock_ready = 1; step(); bus.lock_ready = 0;
    check_val("lock_release_valid", 32'(bus.lock_valid), 32'd0);
    check_val("lock_respawn_req", 32'(bus.next_req), 32'd1);
    check_val("lock_respawn_active", 32'(bus.piece_active), 32'd0);

    // Spawn onto an occupied cell
    bus.board_occ = '0; bus.board_occ[4] = 1'b1;
    do_reset();
    bus.piece_type = 3'd2;
    step(); step();
    check_val("over_flag", 32'(bus.game_over), 32'd1);
    check_val("over_active", 32'(bus.piece_active), 32'd1);
    check_val("over_x", 32'(pack_c(bus.x)), 32'(pk4(3, 4, 5, 4)));
    for (int k = 0; k < 6; k++) begin
      bus.frame_tick = 1; bus.cmd_down = (k % 2 == 0); bus.cmd_left = (k % 2 == 1); step();
    end
    check_val("over_frozen_x", 32'(pack_c(bus.x)), 32'(pk4(3, 4, 5, 4)));
    check_val("over_frozen_y", 32'(pack_c(bus.y)), 32'(pk4(0, 0, 0, 1)));
    do_reset();
    check_val("over_cleared", 32'(bus.game_over), 32'd0);

    // Reset wins over a pending lock handshake
    bus.board_occ = '0;
    bus.piece_type = 3'd1;
    step(); step();
    for (int k = 0; k < 60 && !bus.lock_valid; k++) begin
      bus.cmd_down = 1; step();
    end
    check_val("o_lock_reached", 32'(bus.lock_valid), 32'd1);
    reset = 1; bus.lock_ready = 1; step();
    reset = 0; bus.lock_ready = 0;
    check_val("rst_lock_valid_lk", 32'(bus.lock_valid), 32'd0);
    check_val("rst_active_lk", 32'(bus.piece_active), 32'd0);
    check_val("rst_x_lk", 32'(pack_c(bus.x)), 32'd0);
    check_val("rst_y_lk", 32'(pack_c(bus.y)), 32'd0);
    check_val("rst_no_lock_write", 32'(bus.board_occ[199:160] != '0), 32'd0);

    // Random play
    for (int n = 0; n < 2500; n++) begin
      bus.frame_tick = ($urandom_range(0, 3) == 0);
      bus.cmd_left   = ($urandom_range(0, 5) == 0);
      bus.cmd_right  = ($urandom_range(0, 5) == 0);
      bus.cmd_rot    = ($urandom_range(0, 5) == 0);
      bus.cmd_down   = ($urandom_range(0, 7) == 0);
      bus.piece_type = 3'($urandom_range(0, 7));
      bus.lock_ready = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 599) == 0) || (m_ph == M_OVER && $urandom_range(0, 9) == 0);
      if (reset) begin
        bus.board_occ = '0;
        for (int c = 150; c < CELLS; c++)
          if ($urandom_range(0, 3) == 0) bus.board_occ[8'(c)] = 1'b1;
      end
      step();
    end
    reset = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/piece_controller.md
Name: piece_controller

Overview:
- Sequences the falling tetromino on the 10x20 playfield. Owns the four block coordinates that the shape renderer draws, as x[3:0] and y[3:0] in 5-bit cell units.
- Applies gravity from frame ticks and player move/rotate commands, each gated by a wall and board collision check.
- On landing, hands the piece to the board store through a valid/ready lock handshake, then spawns the next piece.
- Sits between the keycode decoder, the random piece generator, the board occupancy store and the renderer.

Parameters:
- COLS, 10, playfield width in cells.
- ROWS, 20, playfield height in cells.
- DROP_FRAMES, 30, frame ticks per gravity step (must be at least 1).
- SPAWN_COL, 3, column offset added to spawn shape table x values.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- cmd_left, cmd_right, cmd_rot, cmd_down  in  1 each  one-cycle command pulses.
- piece_type  in  3  next piece: 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L, 7 treated as I.
- next_req  out  1  one-cycle pulse; piece_type has been consumed.
- board_occ  in  COLS*ROWS  occupancy; bit y*COLS+x set means the cell is filled.
- x  out  5 x [3:0]  block columns.
- y  out  5 x [3:0]  block rows.
- piece_active  out  1  x/y hold a valid piece to draw.
- lock_valid  out  1  piece landed; x/y are the cells to write.
- lock_ready  in  1  board store accepts the lock.
- game_over  out  1  spawn collided; sticky until Reset.

Behaviour:
- Reset (synchronous): x=y=0 for all blocks, piece_active=0, lock_valid=0, game_over=0, next_req=0, drop counter=0, gravity_pending=0, state=SPAWN.
- States: SPAWN, FALL, CHECK, LOCK, OVER.
- SPAWN (1 cycle):
  - Loads the candidate from the shape table using piece_type; x gets +SPAWN_COL.
  - Pulses next_req, clears the drop counter, sets op=SPAWN, goes to CHECK.
  - piece_active=0 in this state.
- FALL accepts at most one operation per cycle. Priority: gravity_pending, then cmd_down, then cmd_rot, then cmd_left, then cmd_right.
  - Any lower-priority command in the same cycle is dropped.
  - Commands arriving outside FALL are dropped.
  - The candidate is registered and the state goes to CHECK.
  - cmd_down also clears the drop counter. Taking gravity clears gravity_pending.
- Candidate arithmetic uses 6-bit signed values.
  - Left: x-1. Right: x+1. Down/gravity: y+1.
  - Rotate is clockwise about block 1 (the pivot): (px-(y-py), py+(x-px)).
  - O piece: rotate is accepted but not applied; the candidate equals the current position.
- CHECK (1 cycle): the candidate collides if any block has x<0, x>=COLS, y<0, y>=ROWS, or its board_occ bit set.
  - Free: commit the candidate to x/y and go to FALL. If op=SPAWN, set piece_active=1.
  - Collides, op left/right/rot: keep x/y and go to FALL.
  - Collides, op down/gravity: go to LOCK.
  - Collides, op SPAWN: commit the candidate anyway, set piece_active=1 and game_over=1, go to OVER.
- Latency: a command accepted in cycle N updates x/y visibly in cycle N+2.
- Gravity:
  - Each frame_tick in FALL or CHECK increments the drop counter.
  - On the tick where counter==DROP_FRAMES-1, the counter goes to 0 and gravity_pending is set.
  - A pending gravity is held until FALL consumes it.
  - The counter holds in LOCK and OVER.
- LOCK:
  - lock_valid=1; x/y are stable; piece_active stays 1.
  - On the cycle where lock_valid && lock_ready, go to SPAWN. lock_valid drops the next cycle.
  - The board store must reflect the locked cells in board_occ within 1 cycle of the handshake.
- OVER: everything held; only Reset exits.
- Reset mid-operation (including during LOCK with lock_ready high): reset wins; no lock is performed.

Decomposition:
- Package tetris_pkg holds:
  - typedef piece_t (3-bit enum), typedef coord_t (logic [4:0]), ctrl_state_t, op_t.
  - Constants COLS and ROWS.
  - Spawn shape table (before SPAWN_COL is added):
    - I: (0,0)(1,0)(2,0)(3,0)
    - O: (1,0)(2,0)(1,1)(2,1)
    - T: (0,0)(1,0)(2,0)(1,1)
    - S: (1,0)(2,0)(0,1)(1,1)
    - Z: (0,0)(1,0)(1,1)(2,1)
    - J: (0,0)(1,0)(2,0)(2,1)
    - L: (0,0)(1,0)(2,0)(0,1)
  - In every shape, block 1 is the pivot.
- Sub-module piece_collide: purely combinational; candidate x/y plus board_occ in, collide out. It is reused by a future hard-drop/ghost block.

Test Plan:
- Reset, then piece_type=2 (T) with board_occ all 0 -> next_req pulses once. Two cycles later x={3,4,5,4}, y={0,0,0,1}, piece_active=1.
- T at spawn, cmd_rot -> rejected (block 0 goes to y=-1), x/y unchanged. After one cmd_down, cmd_rot -> x={4,4,4,3}, y={0,1,2,1}.
- I at spawn: three cmd_left pulses, then a fourth -> x ends {0,1,2,3} and the fourth leaves it unchanged. Also: frame_tick and cmd_left in the same FALL cycle with gravity pending -> only the down move occurs.
- DROP_FRAMES=2, piece falling on an empty board -> y increments every 2 frame ticks. At row 19 the next gravity sets lock_valid; hold lock_ready=0 for 5 cycles -> x/y stable. Then lock_ready=1 for 1 cycle -> SPAWN follows.
- board_occ bit 4 (cell 4,0) set, T spawns -> game_over=1, piece_active=1, state OVER. Later commands and ticks change nothing; Reset clears game_over.
- Reset asserted while in LOCK with lock_ready=1 -> next cycle lock_valid=0, piece_active=0, x/y all 0.
